image_scaler: RTL
=================

IMAGE_SCALER -- requirements
Module: image_scaler

Interface
REQ-001 Parameter IMG_W, default 4: input image width in pixels; power of two, >=2.
REQ-002 Parameter IMG_H, default 4: input image height in pixels; power of two, >=2.
REQ-003 Parameter PIX_W, default 8: pixel width in bits.
REQ-004 Parameter MAX_SCALE, default 8: largest factor F, from the set 1/2/4/8.
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-008 Port mode  input  2  00 bypass, 01 zoom-in (replicate), 10 zoom-out (decimate), 11 zoom-out (block average).
REQ-009 Port scale  input  2  factor F = 2^scale.
REQ-010 Port in_valid  input  1  in_pixel is valid.
REQ-011 Port in_pixel  input  PIX_W  raster-order input pixel.
REQ-012 Port in_ready  output  1  block accepts in_pixel this cycle.
REQ-013 Port out_valid  output  1  out_pixel is valid.
REQ-014 Port out_pixel  output  PIX_W  raster-order output pixel.
REQ-015 Port out_ready  input  1  downstream accepts out_pixel this cycle.
REQ-016 Port busy  output  1  high in any state other than IDLE.
REQ-017 Port done  output  1  one-cycle pulse marking frame completion.
REQ-018 Port err  output  1  one-cycle pulse marking a rejected start.

Function
REQ-019 Transfers SHALL occur only on cycles where valid and ready are both high.
- out_pixel SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 FSM SHALL have states IDLE, LOAD, EMIT, STREAM and FIN.
REQ-021 IDLE+start SHALL latch mode and scale, then go to LOAD for mode 01, or to STREAM for 00/10/11.
- start outside IDLE SHALL be ignored.
REQ-022 start SHALL be rejected when F>MAX_SCALE, or when mode is 10/11 and F>IMG_W or F>IMG_H.
- Rejection: err=1 on the next cycle; FSM stays in IDLE.
REQ-023 LOAD SHALL hold in_ready=1 and write IMG_W accepted pixels into a line buffer.
- Accepting the last pixel of the row SHALL move the FSM to EMIT.
REQ-024 EMIT SHALL hold in_ready=0 and output the buffered row F times.
- Each pixel is repeated F times consecutively: IMG_W*F pixels per output row.
- out_valid SHALL rise on the cycle after the row's last input pixel is accepted.
REQ-025 EMIT exit: after the last repetition is accepted, go to LOAD if input rows remain, else FIN.
REQ-026 STREAM SHALL drive in_ready = !out_valid || out_ready.
REQ-027 Bypass (00): every accepted pixel SHALL appear on out_pixel on the next cycle (latency 1); F is ignored.
REQ-028 Decimate (10): only pixels at column%F==0 and row%F==0 are emitted, with latency 1.
- All other accepted pixels SHALL be consumed silently.
REQ-029 Average (11): per-column-block accumulators of width PIX_W+2*log2(MAX_SCALE) sum each FxF block.
- After the block's bottom-right pixel is accepted, out_pixel = sum >> (2*scale) on the next cycle, truncated.
- That block's accumulator SHALL then clear.
REQ-030 Column/row counters SHALL wrap at IMG_W-1/IMG_H-1.
- STREAM SHALL go to FIN once the last input pixel is accepted and its output, if any, is accepted.
REQ-031 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-032 With F=1, modes 01/10/11 SHALL produce output identical to bypass.

Reset
REQ-033 reset SHALL immediately force IDLE, clear all counters and accumulators, and drive low in_ready, out_valid, busy, done, err and out_pixel.
REQ-034 reset mid-frame SHALL abort the frame with no done pulse; line-buffer contents are don't-care.

Verification
REQ-035 4x4 image, mode 01, scale 1, in_pixel 0..15, out_ready=1 -> 64 outputs; rows 0 and 1 = 0,0,1,1,2,2,3,3; last output 15; one done pulse.
REQ-036 mode 10, scale 1, in_pixel 0..15 -> outputs exactly 0,2,8,10, then done.
REQ-037 mode 11, scale 1, in_pixel 0..15 -> outputs 2,4,10,12 (sums 10,18,42,50 >> 2), then done.
REQ-038 mode 01, scale 1, out_ready=0 for 3 cycles mid-row -> out_pixel and out_valid stable, in_ready=0; the 64-pixel sequence is unchanged.
REQ-039 mode 10, scale 3 on 4x4 -> err pulse next cycle, busy stays 0; mode 01, scale 3 -> 1024 outputs (32x32).
REQ-040 reset asserted during EMIT -> out_valid/busy drop at once without waiting for a clock edge; the next start runs a clean frame.

Source files
------------

// File: rtl/image_scaler_if.sv
// Pixel stream interface: valid/ready input and output channels of the image scaler.
interface image_scaler_if #(parameter int PIX_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;

  modport master (output in_valid, in_pixel, out_ready, input in_ready, out_valid, out_pixel);
  modport slave  (input in_valid, in_pixel, out_ready, output in_ready, out_valid, out_pixel);
endinterface

// File: rtl/image_scaler.sv
// Raster image scaler: bypass, zoom-in by replication, zoom-out by decimation or FxF block average.
// Zoom-in buffers one row and replays it F times; streaming modes use a single output register.
module image_scaler #(
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int PIX_W     = 8,
  parameter int MAX_SCALE = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [1:0]    scale,
  image_scaler_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = $clog2(MAX_SCALE);
  localparam int AW = PIX_W + 2*SW;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, STREAM, FIN} state_t;
  state_t r_state, w_next;

  logic [1:0]       r_mode, r_scale;
  logic [CW-1:0]    r_col, r_ecol;
  logic [RW-1:0]    r_row;
  logic [2:0]       r_prep, r_rrep;
  logic             r_out_valid, r_err, r_last_in;
  logic [PIX_W-1:0] r_out_pixel;
  logic [PIX_W-1:0] r_line [IMG_W];
  logic [AW-1:0]    r_acc [IMG_W];

  logic             w_in_ready, w_in_acc, w_out_acc, w_reject;
  logic [3:0]       w_req_f;
  logic [2:0]       w_fm1;
  logic [CW-1:0]    w_cmask, w_col_nx, w_blk;
  logic [RW-1:0]    w_rmask;
  logic             w_col_last, w_row_last, w_blk_end, w_emit_last, w_s_emit;
  logic [AW-1:0]    w_sum, w_avg;
  logic [PIX_W-1:0] w_s_pix;

  assign w_req_f  = 4'd1 << scale;
  assign w_reject = (int'(w_req_f) > MAX_SCALE) ||
                    (mode[1] && (int'(w_req_f) > IMG_W || int'(w_req_f) > IMG_H));

  assign w_fm1      = 3'((4'd1 << r_scale) - 4'd1);
  assign w_cmask    = CW'((32'd1 << r_scale) - 32'd1);
  assign w_rmask    = RW'((32'd1 << r_scale) - 32'd1);
  assign w_in_acc   = bus.in_valid && w_in_ready;
  assign w_out_acc  = r_out_valid && bus.out_ready;
  assign w_col_last = (r_col == CW'(IMG_W-1));
  assign w_row_last = (r_row == RW'(IMG_H-1));
  assign w_col_nx   = w_col_last ? '0 : r_col + 1'b1;
  assign w_blk      = r_col >> r_scale;
  assign w_blk_end  = ((r_col & w_cmask) == w_cmask) && ((r_row & w_rmask) == w_rmask);
  assign w_sum      = r_acc[w_blk] + AW'(bus.in_pixel);
  assign w_avg      = w_sum >> {r_scale, 1'b0};
  assign w_emit_last = (r_prep == w_fm1) && (r_ecol == CW'(IMG_W-1)) && (r_rrep == w_fm1);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pixel = r_out_pixel;
  assign err           = r_err;

  always_comb begin
    w_s_emit = 1'b1;
    w_s_pix  = bus.in_pixel;
    case (r_mode)
      2'b10: w_s_emit = ((r_col & w_cmask) == '0) && ((r_row & w_rmask) == '0);
      2'b11: begin
        w_s_emit = w_blk_end;
        w_s_pix  = w_avg[PIX_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    busy       = (r_state != IDLE);
    done       = 1'b0;
    case (r_state)
      IDLE:   if (start && !w_reject) w_next = (mode == 2'b01) ? LOAD : STREAM;
      LOAD: begin
        w_in_ready = 1'b1;
        if (w_in_acc && w_col_last) w_next = EMIT;
      end
      EMIT:   if (w_out_acc && w_emit_last) w_next = w_row_last ? FIN : LOAD;
      STREAM: begin
        // Stop accepting once the frame's last pixel is in, even if upstream keeps pushing.
        w_in_ready = (!r_out_valid || bus.out_ready) && !r_last_in;
        if (r_last_in && !r_out_valid) w_next = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == LOAD && w_in_acc) r_line[r_col] <= bus.in_pixel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= '0; r_scale <= '0; r_col <= '0; r_row <= '0; r_ecol <= '0;
      r_prep <= '0; r_rrep <= '0; r_out_valid <= 1'b0; r_out_pixel <= '0;
      r_err <= 1'b0; r_last_in <= 1'b0;
      for (int i = 0; i < IMG_W; i++) r_acc[i] <= '0;
    end else begin
      r_err <= (r_state == IDLE) && start && w_reject;
      case (r_state)
        IDLE: if (start && !w_reject) begin
          r_mode <= mode; r_scale <= scale; r_col <= '0; r_row <= '0;
          r_ecol <= '0; r_prep <= '0; r_rrep <= '0; r_last_in <= 1'b0;
          for (int i = 0; i < IMG_W; i++) r_acc[i] <= '0;
        end
        LOAD: if (w_in_acc) begin
          r_col <= w_col_nx;
          if (w_col_last) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= r_line[0];
            r_ecol <= '0; r_prep <= '0; r_rrep <= '0;
          end
        end
        EMIT: if (w_out_acc) begin
          if (r_prep != w_fm1) begin
            r_prep <= r_prep + 1'b1;
          end else begin
            r_prep <= '0;
            if (r_ecol != CW'(IMG_W-1)) begin
              r_ecol      <= r_ecol + 1'b1;
              r_out_pixel <= r_line[r_ecol + 1'b1];
            end else begin
              r_ecol      <= '0;
              r_out_pixel <= r_line[0];
              if (r_rrep != w_fm1) begin
                r_rrep <= r_rrep + 1'b1;
              end else begin
                r_rrep      <= '0;
                r_out_valid <= 1'b0;
                r_row       <= w_row_last ? '0 : r_row + 1'b1;
              end
            end
          end
        end
        STREAM: begin
          if (w_out_acc) r_out_valid <= 1'b0;
          if (w_in_acc) begin
            r_col <= w_col_nx;
            if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
            if (w_col_last && w_row_last) r_last_in <= 1'b1;
            if (r_mode == 2'b11) r_acc[w_blk] <= w_blk_end ? '0 : w_sum;
            if (w_s_emit) begin
              r_out_valid <= 1'b1;
              r_out_pixel <= w_s_pix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
